exec_writeback_ctrl: RTL
========================

# exec_writeback_ctrl

Multi-cycle execute/write-back controller for the 4-bit MIPS datapath. It accepts 16-bit instructions from the fetch stage over a valid/ready handshake and drives the register file read addresses. It captures the returned operands, performs the 4-bit ALU operation, and issues the write-back (`reg_write`, `write_reg`, `write_data`) into the register file. The block is the only master of the register file ports.

## Interface
Parameters:
- `DW`, 4: data width; fixed at 4 for this core.
- `IW`, 16: instruction width; fixed at 16.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  fetch presents an instruction.
- `instr`  in  16  instruction word: `op=[15:12]`, `rs=[11:8]`, `rt=[7:4]`, `rd/imm=[3:0]`.
- `instr_ready`  out  1  block can accept an instruction.
- `read_reg1`, `read_reg2`  out  4 each  register file read addresses.
- `read_data1`, `read_data2`  in  4 each  register file combinational read data.
- `reg_write`  out  1  write enable to the register file.
- `write_reg`  out  4  write address.
- `write_data`  out  4  write data.
- `retired`  out  1  one-cycle pulse, instruction completed.
- `halted`  out  1  HALT executed; sticky.
- `illegal`  out  1  undefined opcode seen; sticky.
- `flag_z`, `flag_c`  out  1 each  zero and carry flags (see Configuration).

## Operation
- States: `IDLE`, `READ`, `EXEC`, `WB`, `HALT`. Reset enters `IDLE`.
- `instr_ready` = (state == `IDLE`). It is combinational, so it reads 1 while `rst_n` is low; fetch must not assert `instr_valid` during reset.
- `IDLE`: on `instr_valid && instr_ready`, latch `instr` and go to `READ`.
- `READ`: drive `read_reg1`=rs and `read_reg2`=rt from the latched instruction. At the cycle end, capture `read_data1`/`read_data2` into operand registers. Go to `EXEC`.
- `EXEC`: compute the result into the 4-bit result register. Destination is rd (`[3:0]`) for R-type and rt (`[7:4]`) for I-type. Go to `WB`, or to `HALT` for op F.
- Opcodes:
  - 0 NOP: no write.
  - 1 ADD: rd = rs + rt.
  - 2 SUB: rd = rs − rt.
  - 3 AND: rd = rs & rt.
  - 4 OR: rd = rs | rt.
  - 5 XOR: rd = rs ^ rt.
  - 6 ADDI: rt = rs + imm.
  - 7 LI: rt = imm.
  - 8 SLT: rd = (rs < rt, unsigned) ? 1 : 0.
  - F HALT.
  - 9–E illegal: set `illegal`, no write.
- Arithmetic is modulo 16; carry out / borrow is discarded from the result.
- `WB`: assert `reg_write` for exactly this cycle, with `write_reg`/`write_data` registered and stable for the same cycle. NOP and illegal ops pass through `WB` with `reg_write`=0. Pulse `retired`, then go to `IDLE`.
- `HALT`: absorbing state until reset. `halted`=1, `instr_ready`=0, `reg_write`=0, no `retired` pulse.
- All 16 registers are writable, including r0; there is no hardwired zero.
- Reset mid-instruction: state returns to `IDLE` immediately and all registered outputs clear. No partial write occurs, because `reg_write` clears asynchronously.

## Timing
- Accept edge = cycle 0; `READ` = cycle 1; `EXEC` = cycle 2; `WB` = cycle 3, with the register file written at the end of cycle 3.
- `instr_ready` is high again in cycle 4. Throughput is one instruction per 4 cycles, and latency is uniform for all non-HALT ops.
- No RAW hazard: the next instruction's `READ` occurs at the earliest in cycle 5, after the write edge.
- Reset values:
  - `read_reg1`, `read_reg2`, `write_reg`, `write_data`: 0.
  - `reg_write`, `retired`, `halted`, `illegal`: 0.
  - `flag_z`, `flag_c`: 0.
- `read_reg1`/`read_reg2` hold their value outside `READ`.

## Configuration
- Macro `EXEC_ALU_FLAGS_EN`.
- Defined: `flag_z` and `flag_c` update in `EXEC` for ops 1–6 and 8.
  - `flag_z` = (result == 0).
  - `flag_c` = carry out for ADD/ADDI, borrow for SUB, 0 for logic ops and SLT.
  - LI, NOP, illegal and HALT leave the flags unchanged.
- Undefined: `flag_z` and `flag_c` are tied to 0 and no flag logic is synthesized.

## Test plan
- Reset, then LI r3,9 (`0x7039`): `reg_write`=1 only in cycle 3 with `write_reg`=3, `write_data`=9; `retired` pulses in cycle 3; `instr_ready` is 1 in cycle 4.
- r1=7, r2=12, ADD r4=r1+r2 (`0x1124`): `write_data`=3 (wrap). With `EXEC_ALU_FLAGS_EN`, `flag_c`=1 and `flag_z`=0.
- SUB r5=r2−r2 (`0x2225`): `write_data`=0; `flag_z`=1, `flag_c`=0. Back-to-back LI r6 then ADD using r6 reads the new value with no stall beyond the 4 cycles.
- Opcode `0xB`: `illegal`=1 (sticky), `reg_write` stays 0, `retired` still pulses, and the following instruction executes normally.
- HALT (`0xF000`): `halted`=1 from cycle 3; `instr_ready` stays 0 with `instr_valid` held high for 20 cycles; `rst_n` low clears `halted` and returns to `IDLE`.
- Assert `rst_n` low during `EXEC` of ADD: `reg_write` is never asserted; after release, the register file still holds its prior value and the next LI completes normally.

Source files
------------

// File: rtl/exec_writeback_ctrl_if.sv
// ============================================================================
// exec_writeback_ctrl_if : fetch handshake and register-file port bundle
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface exec_writeback_ctrl_if #(
  parameter int DW = 4,
  parameter int IW = 16
);
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic          instr_ready;
  logic [3:0]    read_reg1;
  logic [3:0]    read_reg2;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic          reg_write;
  logic [3:0]    write_reg;
  logic [DW-1:0] write_data;

  // master: the execute/write-back controller
  modport master (
    input  instr_valid, instr, read_data1, read_data2,
    output instr_ready, read_reg1, read_reg2, reg_write, write_reg, write_data
  );

  // slave: fetch stage plus register file
  modport slave (
    output instr_valid, instr, read_data1, read_data2,
    input  instr_ready, read_reg1, read_reg2, reg_write, write_reg, write_data
  );
endinterface

`default_nettype wire

// File: rtl/exec_writeback_ctrl.sv
// ============================================================================
// exec_writeback_ctrl : 4-cycle execute/write-back controller, 4-bit MIPS core
// Optional zero/carry flags enabled by macro EXEC_ALU_FLAGS_EN
// Revision 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module exec_writeback_ctrl #(
  parameter int DW = 4,
  parameter int IW = 16
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  exec_writeback_ctrl_if.master        bus,
  output logic                         retired,
  output logic                         halted,
  output logic                         illegal,
  output logic                         flag_z,
  output logic                         flag_c
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    EXEC = 3'd2,
    WB   = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t        state;
  logic [3:0]    op_q;
  logic [3:0]    imm_q;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;

  logic [DW-1:0] alu_res;
  logic [3:0]    alu_dst;
  logic          alu_we;
  logic          alu_ill;

  assign bus.instr_ready = (state == IDLE);

  // rt is still held in read_reg2, so it doubles as the I-type destination
  always_comb begin
    alu_res = '0;
    alu_dst = imm_q;
    alu_we  = 1'b0;
    alu_ill = 1'b0;
    case (op_q)
      4'h0: ;
      4'h1: begin alu_res = op_a + op_b; alu_we = 1'b1; end
      4'h2: begin alu_res = op_a - op_b; alu_we = 1'b1; end
      4'h3: begin alu_res = op_a & op_b; alu_we = 1'b1; end
      4'h4: begin alu_res = op_a | op_b; alu_we = 1'b1; end
      4'h5: begin alu_res = op_a ^ op_b; alu_we = 1'b1; end
      4'h6: begin alu_res = op_a + imm_q; alu_dst = bus.read_reg2; alu_we = 1'b1; end
      4'h7: begin alu_res = imm_q;        alu_dst = bus.read_reg2; alu_we = 1'b1; end
      4'h8: begin alu_res = {{(DW-1){1'b0}}, (op_a < op_b)}; alu_we = 1'b1; end
      4'hF: ;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      op_q           <= 4'h0;
      imm_q          <= 4'h0;
      op_a           <= '0;
      op_b           <= '0;
      bus.read_reg1  <= 4'h0;
      bus.read_reg2  <= 4'h0;
      bus.reg_write  <= 1'b0;
      bus.write_reg  <= 4'h0;
      bus.write_data <= '0;
      retired        <= 1'b0;
      halted         <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      bus.reg_write <= 1'b0;
      retired       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            op_q          <= bus.instr[IW-1 -: 4];
            imm_q         <= bus.instr[3:0];
            bus.read_reg1 <= bus.instr[11:8];
            bus.read_reg2 <= bus.instr[7:4];
            state         <= READ;
          end
        end
        READ: begin
          op_a  <= bus.read_data1;
          op_b  <= bus.read_data2;
          state <= EXEC;
        end
        EXEC: begin
          if (op_q == 4'hF) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            bus.reg_write <= alu_we;
            if (alu_we) begin
              bus.write_reg  <= alu_dst;
              bus.write_data <= alu_res;
            end
            if (alu_ill) begin
              illegal <= 1'b1;
            end
            retired <= 1'b1;
            state   <= WB;
          end
        end
        WB:      state <= IDLE;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXEC_ALU_FLAGS_EN
  logic flag_upd;
  logic carry;

  // modulo sum wrapped below its first addend exactly when a carry occurred
  always_comb begin
    flag_upd = 1'b0;
    carry    = 1'b0;
    case (op_q)
      4'h1, 4'h6: begin flag_upd = 1'b1; carry = (alu_res < op_a); end
      4'h2:       begin flag_upd = 1'b1; carry = (op_a < op_b); end
      4'h3, 4'h4, 4'h5, 4'h8: flag_upd = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if ((state == EXEC) && flag_upd) begin
      flag_z <= (alu_res == '0);
      flag_c <= carry;
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

`default_nettype wire
